instruction_decode: RTL
=======================

INSTRUCTION_DECODE -- requirements
Module: instruction_decode

Interface
REQ-001 SHALL have parameter REG_COUNT, default 16, number of architectural registers (4-bit index).
REQ-002 SHALL have parameter DATA_W, default 32, register and operand width.
REQ-003 SHALL have port clk, input, 1, single clock; all state on rising edge.
REQ-004 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port fetchIn, input, 56, fetch buffer word {instruction[31:0], pc[23:0]}.
REQ-006 SHALL have port fetchValid, input, 1, fetchIn holds a real instruction.
REQ-007 SHALL have ports wbEn, input, 1; wbAddr, input, 4; wbData, input, 32; register write-back.
REQ-008 SHALL have port stall, output, 1, fetch must hold pc and buffer this cycle.
REQ-009 SHALL have ports branchFlag, output, 1; branchAddr, output, 24; redirect to fetch.
REQ-010 SHALL have port flush, output, 1, clear fetch buffer; equals branchFlag.
REQ-011 SHALL have ports exValid, 1; exOp, 5; exRd, 4; exA, 32; exB, 32; exImm, 32; exPc, 24; illegal, 1; all outputs, registered, to execute.

Function
REQ-012 SHALL decode fields: op=[31:27], rd=[26:23], rs1=[22:19], rs2=[18:15], imm=[14:0] sign-extended.
REQ-013 SHALL support opcodes NOP=0, ADD=1, SUB=2, ADDI=3, LOAD=4, STORE=5, BEQ=6, JMP=7; others set illegal=1 with exValid=0 for that slot.
REQ-014 SHALL read rs1/rs2 from a REG_COUNT x DATA_W register file; r0 reads 0, writes to r0 ignored.
REQ-015 SHALL bypass write-back: wbEn && wbAddr==rsX && rsX!=0 -> operand = wbData same cycle.
REQ-016 SHALL write wbData into wbAddr on the rising edge when wbEn=1.
REQ-017 SHALL register decoded outputs with 1-cycle latency: instruction accepted at edge N appears on ex* after edge N.
REQ-018 SHALL assert stall combinationally when exValid && exOp==LOAD && exRd!=0 && exRd matches a used source (rs1 for ADD/SUB/ADDI/LOAD/STORE/BEQ; rs2 for ADD/SUB/STORE/BEQ) of the current fetchIn.
REQ-019 SHALL load a bubble (exValid=0, other ex* 0) on a stall edge; stall lasts exactly one cycle per hazard.
REQ-020 SHALL evaluate BEQ (taken if A==B after bypass) and JMP (always) only when fetchValid && !stall && state RUN.
REQ-021 SHALL compute branchAddr = pc + sign-extended imm, modulo 2^24 (wrap-around, no flag).
REQ-022 SHALL assert branchFlag/flush combinationally in the decode cycle of a taken branch; branch still issues to ex* with exValid=1.
REQ-023 SHALL implement FSM RUN/SQUASH: RUN->SQUASH on taken branch edge; SQUASH discards fetchIn (bubble), never stalls or branches, ->RUN next edge.
REQ-024 SHALL treat fetchValid=0 as bubble in any state.
REQ-025 SHALL give stall priority over branch evaluation; a hazarded branch is evaluated on the following cycle.

Reset
REQ-026 SHALL on rst=0 immediately clear all ex* and illegal to 0, registers to 0, FSM to RUN, independent of clk.
REQ-027 SHALL hold stall, branchFlag, flush at 0 while rst=0; first decode on first rising edge after release.

Structure
REQ-028 SHALL place opcode enum, field bit positions, FSM state type, widths in shared package decode_pkg.
REQ-029 SHALL instantiate one sub-module register_file (2 read, 1 write, async reset) in a separate file.

Verification
REQ-030 Write r3=5 via wb, then ADD r1,r3,r3 at pc 0x000010 -> next cycle exA=5, exB=5, exRd=1, exValid=1.
REQ-031 LOAD r2 then ADD r4,r2,r1 back-to-back -> stall=1 one cycle, exValid=0 bubble, ADD issues next cycle.
REQ-032 BEQ r0,r0,imm=-4 at pc 0x000000 -> branchFlag=1, branchAddr=0xFFFFFC, next fetchIn discarded.
REQ-033 wbEn=1 wbAddr=7 wbData=0xDEADBEEF same cycle as ADD reading r7 -> exA=0xDEADBEEF; write to r0 -> reads 0.
REQ-034 Opcode 0x1F -> illegal=1, exValid=0; rst=0 mid-stream -> all outputs 0 before next edge, FSM RUN.

Source files
------------

// File: rtl/decode_pkg.sv
// Shared decode definitions: fetch word layout, instruction field positions,
// opcode encoding and decoder FSM state encoding.
package decode_pkg;

  localparam int PC_W    = 24;
  localparam int FETCH_W = 56;
  localparam int OP_W    = 5;
  localparam int REG_AW  = 4;
  localparam int IMM_W   = 15;

  localparam int OP_MSB  = 31;
  localparam int OP_LSB  = 27;
  localparam int RD_MSB  = 26;
  localparam int RD_LSB  = 23;
  localparam int RS1_MSB = 22;
  localparam int RS1_LSB = 19;
  localparam int RS2_MSB = 18;
  localparam int RS2_LSB = 15;

  typedef enum logic [OP_W-1:0] {
    OP_NOP   = 5'd0,
    OP_ADD   = 5'd1,
    OP_SUB   = 5'd2,
    OP_ADDI  = 5'd3,
    OP_LOAD  = 5'd4,
    OP_STORE = 5'd5,
    OP_BEQ   = 5'd6,
    OP_JMP   = 5'd7
  } opcode_e;

  typedef logic [0:0] state_t;
  localparam state_t ST_RUN    = 1'b0;
  localparam state_t ST_SQUASH = 1'b1;

  function automatic logic is_legal(input logic [OP_W-1:0] op);
    return op <= OP_JMP;
  endfunction

  function automatic logic uses_rs1(input logic [OP_W-1:0] op);
    return op inside {OP_ADD, OP_SUB, OP_ADDI, OP_LOAD, OP_STORE, OP_BEQ};
  endfunction

  function automatic logic uses_rs2(input logic [OP_W-1:0] op);
    return op inside {OP_ADD, OP_SUB, OP_STORE, OP_BEQ};
  endfunction

endpackage

// File: rtl/register_file.sv
// Two-read, one-write architectural register file with write-back bypass;
// r0 is hard-wired to zero.
module register_file #(
  parameter int REG_COUNT = 16,
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] rd_addr_a,
  output logic [DATA_W-1:0] rd_data_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_b,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data
);

  logic [DATA_W-1:0] regs [REG_COUNT];

  // NOTE: this array is architectural state that must read as zero after reset,
  // so it is built from resettable flops rather than left as an unreset RAM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < REG_COUNT; i++) regs[i] <= '0;
    end else if (wr_en && wr_addr != '0) begin
      regs[wr_addr] <= wr_data;
    end
  end

  // A write landing this cycle is forwarded so decode sees the newest value.
  always_comb begin
    rd_data_a = regs[rd_addr_a];
    if (wr_en && wr_addr == rd_addr_a) rd_data_a = wr_data;
    if (rd_addr_a == '0) rd_data_a = '0;
    rd_data_b = regs[rd_addr_b];
    if (wr_en && wr_addr == rd_addr_b) rd_data_b = wr_data;
    if (rd_addr_b == '0) rd_data_b = '0;
  end

endmodule

// File: rtl/instruction_decode.sv
// Decode stage: field extraction, operand read, load-use stall, branch
// resolution with a one-slot squash, and the registered hand-off to execute.
module instruction_decode
  import decode_pkg::*;
#(
  parameter int REG_COUNT = 16,
  parameter int DATA_W    = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [FETCH_W-1:0] fetchIn,
  input  logic               fetchValid,
  input  logic               wbEn,
  input  logic [REG_AW-1:0]  wbAddr,
  input  logic [DATA_W-1:0]  wbData,
  output logic               stall,
  output logic               branchFlag,
  output logic [PC_W-1:0]    branchAddr,
  output logic               flush,
  output logic               exValid,
  output logic [OP_W-1:0]    exOp,
  output logic [REG_AW-1:0]  exRd,
  output logic [DATA_W-1:0]  exA,
  output logic [DATA_W-1:0]  exB,
  output logic [DATA_W-1:0]  exImm,
  output logic [PC_W-1:0]    exPc,
  output logic               illegal
);

  logic [PC_W-1:0]   pc;
  logic [OP_W-1:0]   op;
  logic [REG_AW-1:0] rd, rs1, rs2;
  logic [IMM_W-1:0]  imm;
  logic [DATA_W-1:0] imm_ext, opa, opb;
  logic              live, hazard, accept, taken;
  state_t            state;

  assign pc      = fetchIn[PC_W-1:0];
  assign op      = fetchIn[PC_W+OP_MSB:PC_W+OP_LSB];
  assign rd      = fetchIn[PC_W+RD_MSB:PC_W+RD_LSB];
  assign rs1     = fetchIn[PC_W+RS1_MSB:PC_W+RS1_LSB];
  assign rs2     = fetchIn[PC_W+RS2_MSB:PC_W+RS2_LSB];
  assign imm     = fetchIn[PC_W+IMM_W-1:PC_W];
  assign imm_ext = {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};

  register_file #(
    .REG_COUNT(REG_COUNT),
    .DATA_W   (DATA_W),
    .ADDR_W   (REG_AW)
  ) u_register_file (
    .clk      (clk),
    .rst_n    (rst),
    .rd_addr_a(rs1),
    .rd_data_a(opa),
    .rd_addr_b(rs2),
    .rd_data_b(opb),
    .wr_en    (wbEn),
    .wr_addr  (wbAddr),
    .wr_data  (wbData)
  );

  // NOTE: the combinational outputs are qualified with reset so a stale fetch
  // word can never signal a redirect or stall while the block is held in reset.
  assign live   = rst && fetchValid && (state == ST_RUN);
  assign hazard = exValid && (exOp == OP_LOAD) && (exRd != '0) &&
                  ((uses_rs1(op) && rs1 == exRd) || (uses_rs2(op) && rs2 == exRd));
  assign stall  = live && hazard;
  assign accept = live && !hazard;
  assign taken  = accept && ((op == OP_JMP) || (op == OP_BEQ && opa == opb));

  assign branchFlag = taken;
  assign flush      = taken;
  assign branchAddr = pc + imm_ext[PC_W-1:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= ST_RUN;
      exValid <= 1'b0;
      exOp    <= '0;
      exRd    <= '0;
      exA     <= '0;
      exB     <= '0;
      exImm   <= '0;
      exPc    <= '0;
      illegal <= 1'b0;
    end else begin
      state   <= taken ? ST_SQUASH : ST_RUN;
      // NOTE: every slot defaults to a bubble and is then overridden, so each
      // register gets a value on every edge without a tangle of else arms.
      exValid <= 1'b0;
      exOp    <= '0;
      exRd    <= '0;
      exA     <= '0;
      exB     <= '0;
      exImm   <= '0;
      exPc    <= '0;
      illegal <= 1'b0;
      if (accept) begin
        if (is_legal(op)) begin
          exValid <= 1'b1;
          exOp    <= op;
          exRd    <= rd;
          exA     <= opa;
          exB     <= opb;
          exImm   <= imm_ext;
          exPc    <= pc;
        end else begin
          illegal <= 1'b1;
        end
      end
    end
  end

endmodule
